ima_driver: RTL and testbench



---
 rtl/ima_driver.sv | 185 ++++++++++++++++++
 tb/tb_ima_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ima_driver.sv
`default_nettype none
// ============================================================================
//  Module      : ima_driver
//  Description : Stimulus/driver for the YODA image masking accelerator.
//                Walks a generated IMG_W x IMG_H greyscale image in raster
//                order (one pixel per clock), zeroes pixels outside a
//                rectangular window, streams the masked pixels with their
//                addresses and accumulates a wrapping checksum.
//  Options     : IMA_DRIVER_AUTO_START_EN - implicit start on the first
//                rising edge after reset release (one frame, then the
//                start port keeps working as usual).
//  Revision    : 1.0 - initial release
// ============================================================================
module ima_driver #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int PIX_W  = 8,
    parameter int WIN_X0 = 2,
    parameter int WIN_Y0 = 2,
    parameter int WIN_X1 = 5,
    parameter int WIN_Y1 = 5,
    parameter int CSUM_W = 16
) (
    input  logic                               clk_driver,
    input  logic                               rst_driver,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic                               out_valid,
    output logic [$clog2(IMG_W*IMG_H)-1:0]     out_addr,
    output logic [PIX_W-1:0]                   out_pixel,
    output logic [CSUM_W-1:0]                  checksum
);

    localparam int          c_addr_w = $clog2(IMG_W*IMG_H);
    localparam int          c_x_w    = $clog2(IMG_W);
    localparam int          c_y_w    = $clog2(IMG_H);
    localparam logic [31:0] c_win_x0 = 32'(WIN_X0);
    localparam logic [31:0] c_win_x1 = 32'(WIN_X1);
    localparam logic [31:0] c_win_y0 = 32'(WIN_Y0);
    localparam logic [31:0] c_win_y1 = 32'(WIN_Y1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_start;
    logic                  w_launch;
    logic                  w_step;
    logic                  w_finish;

    logic [c_x_w-1:0]      r_x;
    logic [c_y_w-1:0]      r_y;
    logic [c_addr_w-1:0]   r_pos;      // tracks y*IMG_W+x without a multiplier
    logic                  r_busy;
    logic                  r_done;
    logic                  r_out_valid;
    logic [c_addr_w-1:0]   r_out_addr;
    logic [PIX_W-1:0]      r_out_pixel;
    logic [CSUM_W-1:0]     r_checksum;

    logic                  w_last_x;
    logic                  w_last_y;
    logic                  w_inside;
    logic [PIX_W-1:0]      w_src;
    logic [PIX_W-1:0]      w_masked;

`ifdef IMA_DRIVER_AUTO_START_EN
    logic                  r_auto_pend;

    // One-shot: armed by reset, fires on the first edge after release.
    always_ff @(posedge clk_driver or posedge rst_driver) begin
        if (rst_driver) begin
            r_auto_pend <= 1'b1;
        end else begin
            r_auto_pend <= 1'b0;
        end
    end

    assign w_start = start | r_auto_pend;
`else
    assign w_start = start;
`endif

    // Pixel generation and window mask; an empty window simply never matches.
    assign w_last_x = (r_x == c_x_w'(IMG_W - 1));
    assign w_last_y = (r_y == c_y_w'(IMG_H - 1));
    assign w_src    = PIX_W'(32'(r_pos));
    assign w_inside = (32'(r_x) >= c_win_x0) && (32'(r_x) <= c_win_x1) &&
                      (32'(r_y) >= c_win_y0) && (32'(r_y) <= c_win_y1);
    assign w_masked = w_inside ? w_src : '0;

    // State register; busy is registered so it mirrors state==RUN exactly.
    always_ff @(posedge clk_driver or posedge rst_driver) begin
        if (rst_driver) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_RUN);
        end
    end

    // Next-state decode; start is only honoured outside RUN.
    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next   = S_RUN;
                    w_launch = 1'b1;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last_x && w_last_y) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_start) begin
                    w_next   = S_RUN;
                    w_launch = 1'b1;
                end else begin
                    w_finish = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: frame setup, raster walk with output register, and done.
    always_ff @(posedge clk_driver or posedge rst_driver) begin
        if (rst_driver) begin
            r_x         <= '0;
            r_y         <= '0;
            r_pos       <= '0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_pixel <= '0;
            r_checksum  <= '0;
        end else if (w_launch) begin
            r_x         <= '0;
            r_y         <= '0;
            r_pos       <= '0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_checksum  <= '0;
        end else if (w_step) begin
            r_out_valid <= 1'b1;
            r_out_addr  <= r_pos;
            r_out_pixel <= w_masked;
            r_checksum  <= r_checksum + CSUM_W'(w_masked);
            r_pos       <= r_pos + 1'b1;
            if (w_last_x) begin
                r_x <= '0;
                r_y <= w_last_y ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end else if (w_finish) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_pixel = r_out_pixel;
    assign checksum  = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_ima_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ima_driver
//  Description : Self-checking bench for ima_driver at default parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ima_driver;

    logic       clk_driver;
    logic       rst_driver;
    logic       start;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic [5:0] out_addr;
    logic [7:0] out_pixel;
    logic [15:0] checksum;

    int checks;
    int errors;
    logic [7:0] pix_seen [64];

    typedef struct {
        int addr;
        int pix;
    } vec_t;

    vec_t vecs [12];

    ima_driver dut (
        .clk_driver (clk_driver),
        .rst_driver (rst_driver),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_pixel  (out_pixel),
        .checksum   (checksum)
    );

    initial begin
        clk_driver = 1'b0;
        forever #5 clk_driver = ~clk_driver;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_done"},      32'(done),      0);
        check({tag, "_valid"},     32'(out_valid), 0);
        check({tag, "_addr"},      32'(out_addr),  0);
        check({tag, "_pixel"},     32'(out_pixel), 0);
        check({tag, "_checksum"},  32'(checksum),  0);
    endtask

    // Runs one frame. do_start=0 means the launch edge comes from elsewhere
    // (auto-start); hold keeps start high until the last pixel is seen.
    task automatic run_frame(input bit do_start, input bit hold);
        int  nvalid;
        int  last_v;
        int  done_c;
        bit  order_ok;
        bit  seen_busy;
        nvalid    = 0;
        last_v    = -1;
        done_c    = -1;
        order_ok  = 1'b1;
        seen_busy = 1'b0;
        if (do_start) begin
            @(negedge clk_driver);
            start = 1'b1;
        end
        @(posedge clk_driver);
        #1;
        if (!hold) start = 1'b0;
        check("launch_done_clr", 32'(done), 0);
        check("launch_csum_clr", 32'(checksum), 0);
        for (int c = 1; c <= 200 && done_c < 0; c++) begin
            @(posedge clk_driver);
            #1;
            if (busy) seen_busy = 1'b1;
            if (out_valid) begin
                if (32'(out_addr) != 32'(nvalid) || c != nvalid + 1) order_ok = 1'b0;
                pix_seen[out_addr] = out_pixel;
                nvalid++;
                last_v = c;
                if (hold && out_addr == 6'd63) start = 1'b0;
            end
            if (done) done_c = c;
        end
        check("frame_timeout", 32'(done_c >= 0), 1);
        check("valid_count", 32'(nvalid), 64);
        check("addr_order_no_bubble", 32'(order_ok), 1);
        check("busy_during_frame", 32'(seen_busy), 1);
        check("done_latency", 32'(done_c - last_v), 1);
        check("busy_after_done", 32'(busy), 0);
        check("valid_after_done", 32'(out_valid), 0);
        check("frame_checksum", 32'(checksum), 504);
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        start  = 1'b0;
        rst_driver = 1'b1;

        vecs[0]  = '{18, 18};
        vecs[1]  = '{45, 45};
        vecs[2]  = '{0,  0};
        vecs[3]  = '{23, 0};
        vecs[4]  = '{63, 0};
        vecs[5]  = '{42, 42};
        vecs[6]  = '{34, 34};
        vecs[7]  = '{37, 37};
        vecs[8]  = '{21, 21};
        vecs[9]  = '{22, 0};
        vecs[10] = '{50, 0};
        vecs[11] = '{16, 0};

        repeat (2) @(posedge clk_driver);
        #1;
        check_zero_outputs("reset");

        @(negedge clk_driver);
        rst_driver = 1'b0;

`ifdef IMA_DRIVER_AUTO_START_EN
        run_frame(1'b0, 1'b0);
`else
        @(posedge clk_driver);
        #1;
        check("idle_no_start_valid", 32'(out_valid), 0);
        check("idle_no_start_busy", 32'(busy), 0);
        run_frame(1'b1, 1'b0);
`endif

        for (int i = 0; i < 12; i++) begin
            check($sformatf("pixel_at_%0d", vecs[i].addr),
                  32'(pix_seen[vecs[i].addr]), 32'(vecs[i].pix));
        end

        // DONE holds its outputs while idle.
        repeat (3) @(posedge clk_driver);
        #1;
        check("done_sticky", 32'(done), 1);
        check("csum_hold", 32'(checksum), 504);
        check("addr_hold", 32'(out_addr), 63);
        check("valid_hold_low", 32'(out_valid), 0);

        // Start held high the whole frame: must not restart.
        run_frame(1'b1, 1'b1);

        // Second start after done: done drops, checksum restarts.
        run_frame(1'b1, 1'b0);

        // Reset mid-frame at pixel 30, asserted between clock edges.
        @(negedge clk_driver);
        start = 1'b1;
        @(posedge clk_driver);
        #1;
        start = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 100 && !hit; c++) begin
                @(posedge clk_driver);
                #1;
                if (out_valid && out_addr == 6'd30) hit = 1'b1;
            end
            check("reach_pixel_30", 32'(hit), 1);
        end
        #2;
        rst_driver = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        @(posedge clk_driver);
        @(negedge clk_driver);
        rst_driver = 1'b0;
`ifdef IMA_DRIVER_AUTO_START_EN
        run_frame(1'b0, 1'b0);
`else
        begin
            bit any_valid;
            any_valid = 1'b0;
            repeat (3) begin
                @(posedge clk_driver);
                #1;
                if (out_valid || busy) any_valid = 1'b1;
            end
            check("no_valid_after_reset", 32'(any_valid), 0);
        end
        run_frame(1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
